// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM state encodings,
// instruction opcode/funct constants, ALU operation codes, next-PC and
// extension selects, and fault codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALU operations (zero-extended to the Aluctrl width)
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd4;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Fault codes
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_BUS     = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decode.sv
// Combinational instruction decoder for the EXEC-phase datapath controls.
// Ports:
//   OpCode, funct : instruction fields
//   Aluctrl       : ALU operation (AW bits, upper bits zero)
//   ExtOp         : immediate extension mode
//   Alusrc        : 0 = register operand, 1 = immediate operand
//   legal         : instruction is supported by this configuration
module alu_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int AW      = 3,
    parameter bit HAS_SLT = 1'b1
) (
    input  logic [5:0]    OpCode,
    input  logic [5:0]    funct,
    output logic [AW-1:0] Aluctrl,
    output logic [1:0]    ExtOp,
    output logic          Alusrc,
    output logic          legal
);

    logic [2:0] alu_op;

    always_comb begin
        alu_op = ALU_ADD;
        ExtOp  = EXT_ZERO;
        Alusrc = 1'b1;
        legal  = 1'b1;
        case (OpCode)
            OP_RTYPE: begin
                Alusrc = 1'b0;
                case (funct)
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_SLT: begin
                        alu_op = ALU_SLT;
                        legal  = HAS_SLT;
                    end
                    default: legal = 1'b0;
                endcase
            end
            // Jump completes in DECODE; its EXEC controls are never used.
            OP_J: legal = 1'b1;
            OP_BEQ, OP_BNE: begin
                Alusrc = 1'b0;
                alu_op = ALU_SUB;
            end
            OP_SLTI: begin
                ExtOp  = EXT_SIGN;
                alu_op = ALU_SLT;
                legal  = HAS_SLT;
            end
            OP_ORI: begin
                ExtOp  = EXT_ZERO;
                alu_op = ALU_OR;
            end
            OP_LUI: begin
                ExtOp  = EXT_LUI;
                alu_op = ALU_OR;
            end
            OP_LW, OP_SW: begin
                ExtOp  = EXT_SIGN;
                alu_op = ALU_ADD;
            end
            default: legal = 1'b0;
        endcase
    end

    assign Aluctrl = AW'(alu_op);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   OpCode, funct     : instruction register fields (valid from DECODE)
//   zero              : ALU zero flag, used by beq/bne in EXEC
//   mem_req/mem_ready : memory request / acknowledge
//   mem_we, IorD      : memory write strobe, address select (1 = ALU)
//   IRWrite, PCWrite  : instruction register / PC load strobes
//   PCSrc             : next-PC source
//   RegDst, RegW, Mem2R, Alusrc, ExtOp, Aluctrl : datapath controls
//   state, fault      : current FSM state, latched fault code
// Handshake: a memory transfer completes in any cycle where mem_req and
// mem_ready are both 1 (ready may already be high in the first request
// cycle); mem_ready with mem_req low has no effect.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int AW          = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter bit HAS_SLT     = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [5:0]    OpCode,
    input  logic [5:0]    funct,
    input  logic          zero,
    output logic          mem_req,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic          IorD,
    output logic          IRWrite,
    output logic          PCWrite,
    output logic [1:0]    PCSrc,
    output logic          RegDst,
    output logic          RegW,
    output logic          Mem2R,
    output logic          Alusrc,
    output logic [1:0]    ExtOp,
    output logic [AW-1:0] Aluctrl,
    output logic [2:0]    state,
    output logic [1:0]    fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [1:0]    fault_q, fault_d;
    logic [CW-1:0] wait_q, wait_d;
    // Low during reset and for the first edge after it, so every strobe is
    // quiet while rst_n is asserted without decoding rst_n combinationally.
    logic          run_q;

    logic [AW-1:0] dec_aluctrl;
    logic [1:0]    dec_extop;
    logic          dec_alusrc;
    logic          dec_legal;

    alu_decode #(
        .AW      (AW),
        .HAS_SLT (HAS_SLT)
    ) u_alu_decode (
        .OpCode  (OpCode),
        .funct   (funct),
        .Aluctrl (dec_aluctrl),
        .ExtOp   (dec_extop),
        .Alusrc  (dec_alusrc),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        wait_d  = wait_q;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        IorD    = 1'b0;
        IRWrite = 1'b0;
        PCWrite = 1'b0;
        PCSrc   = PC_PLUS4;
        RegDst  = 1'b0;
        RegW    = 1'b0;
        Mem2R   = 1'b0;
        Alusrc  = 1'b0;
        ExtOp   = EXT_ZERO;
        Aluctrl = '0;

        if (run_q) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        PCSrc   = PC_PLUS4;
                        state_d = ST_DECODE;
                    end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_HALT;
                        fault_d = FAULT_BUS;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
                ST_DECODE: begin
                    if (OpCode == OP_J) begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_JUMP;
                        state_d = ST_FETCH;
                    end else if (!dec_legal) begin
                        fault_d = FAULT_ILLEGAL;
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    Alusrc  = dec_alusrc;
                    ExtOp   = dec_extop;
                    Aluctrl = dec_aluctrl;
                    if (OpCode == OP_BEQ || OpCode == OP_BNE) begin
                        if ((OpCode == OP_BEQ && zero) || (OpCode == OP_BNE && !zero)) begin
                            PCWrite = 1'b1;
                            PCSrc   = PC_BRANCH;
                        end
                        state_d = ST_FETCH;
                    end else if (OpCode == OP_LW || OpCode == OP_SW) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    mem_we  = (OpCode == OP_SW);
                    if (mem_ready) begin
                        state_d = (OpCode == OP_SW) ? ST_FETCH : ST_WB;
                    end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_HALT;
                        fault_d = FAULT_BUS;
                    end else begin
                        wait_d = wait_q + CW'(1);
                    end
                end
                ST_WB: begin
                    RegW    = 1'b1;
                    RegDst  = (OpCode == OP_RTYPE);
                    Mem2R   = (OpCode == OP_LW);
                    state_d = ST_FETCH;
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase

            // Wait counts are per-phase: any state transition starts afresh.
            if (state_d != state_q) begin
                wait_d = '0;
            end
        end
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int W   = 32;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] OpCode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic a_mem_req, a_mem_we, a_IorD, a_IRWrite, a_PCWrite, a_RegDst, a_RegW, a_Mem2R, a_Alusrc;
    logic [1:0] a_PCSrc, a_ExtOp, a_fault;
    logic [2:0] a_Aluctrl, a_state;
    logic b_mem_req, b_mem_we, b_IorD, b_IRWrite, b_PCWrite, b_RegDst, b_RegW, b_Mem2R, b_Alusrc;
    logic [1:0] b_PCSrc, b_ExtOp, b_fault;
    logic [2:0] b_Aluctrl, b_state;

    multicycle_ctrl #(.AW(3), .MEM_TIMEOUT(TMO), .HAS_SLT(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .zero(zero),
        .mem_req(a_mem_req), .mem_ready(mem_ready), .mem_we(a_mem_we), .IorD(a_IorD),
        .IRWrite(a_IRWrite), .PCWrite(a_PCWrite), .PCSrc(a_PCSrc), .RegDst(a_RegDst),
        .RegW(a_RegW), .Mem2R(a_Mem2R), .Alusrc(a_Alusrc), .ExtOp(a_ExtOp),
        .Aluctrl(a_Aluctrl), .state(a_state), .fault(a_fault)
    );

    multicycle_ctrl #(.AW(3), .MEM_TIMEOUT(TMO), .HAS_SLT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .zero(zero),
        .mem_req(b_mem_req), .mem_ready(mem_ready), .mem_we(b_mem_we), .IorD(b_IorD),
        .IRWrite(b_IRWrite), .PCWrite(b_PCWrite), .PCSrc(b_PCSrc), .RegDst(b_RegDst),
        .RegW(b_RegW), .Mem2R(b_Mem2R), .Alusrc(b_Alusrc), .ExtOp(b_ExtOp),
        .Aluctrl(b_Aluctrl), .state(b_state), .fault(b_fault)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    logic [W-1:0] obs_a, obs_b;
    assign obs_a = {11'd0, a_state, a_fault, a_mem_req, a_mem_we, a_IorD, a_IRWrite, a_PCWrite,
                    a_PCSrc, a_RegDst, a_RegW, a_Mem2R, a_Alusrc, a_ExtOp, a_Aluctrl};
    assign obs_b = {11'd0, b_state, b_fault, b_mem_req, b_mem_we, b_IorD, b_IRWrite, b_PCWrite,
                    b_PCSrc, b_RegDst, b_RegW, b_Mem2R, b_Alusrc, b_ExtOp, b_Aluctrl};

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic         rdy_q[$];
    logic         z_q[$];
    bit           need_reset = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [5:0] R = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] SLTI = 6'b001010, ORI = 6'b001101, LUI = 6'b001111;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, SLT = 6'b101010;

    function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [1:0] flt,
                                        input logic req, input logic we, input logic iord,
                                        input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic rdst, input logic rw, input logic m2r,
                                        input logic asrc, input logic [1:0] ext, input logic [2:0] alu);
        return {11'd0, st, flt, req, we, iord, irw, pcw, pcs, rdst, rw, m2r, asrc, ext, alu};
    endfunction

    function automatic bit op_legal(input logic [5:0] op, input logic [5:0] fn, input bit slt_ok);
        case (op)
            R:    return (fn == ADDU) || (fn == SUBU) || (fn == SLT && slt_ok);
            SLTI: return slt_ok;
            J, BEQ, BNE, ORI, LUI, LW, SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] exec_v(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic asrc = 1'b1;
        logic [1:0] ext = 2'b00;
        logic [2:0] alu = 3'd0;
        logic pcw = 1'b0;
        logic [1:0] pcs = 2'b00;
        case (op)
            R: begin
                asrc = 1'b0;
                alu = (fn == ADDU) ? 3'd0 : (fn == SUBU) ? 3'd1 : 3'd4;
            end
            ORI:    alu = 3'd2;
            LUI:    begin ext = 2'b10; alu = 3'd2; end
            LW, SW: begin ext = 2'b01; alu = 3'd0; end
            SLTI:   begin ext = 2'b01; alu = 3'd4; end
            default: begin // beq / bne
                asrc = 1'b0;
                alu = 3'd1;
                if ((op == BEQ) == z) begin pcw = 1'b1; pcs = 2'b01; end
            end
        endcase
        return mk(3'd2, 2'b00, 0, 0, 0, 0, pcw, pcs, 0, 0, 0, asrc, ext, alu);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [W-1:0] v, input logic r, input logic z);
        exp_q.push_back(v);
        rdy_q.push_back(r);
        z_q.push_back(z);
    endtask

    task automatic push_halt(input logic [1:0] flt);
        for (int i = 0; i < 3; i++) push(mk(3'd7, flt, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'd0), rbit(), rbit());
    endtask

    // w cycles of mem_ready low, then the accepting cycle; TMO low cycles halt with a bus fault.
    task automatic wait_phase(input logic [W-1:0] v_wait, input logic [W-1:0] v_go, input int w, output bit tmo);
        tmo = 1'b0;
        for (int i = 0; i < w && i < TMO; i++) push(v_wait, 1'b0, rbit());
        if (w >= TMO) begin
            tmo = 1'b1;
            push_halt(2'b10);
        end else begin
            push(v_go, 1'b1, rbit());
        end
    endtask

    // Expected per-cycle trace of one instruction. zs < 0 picks zero at random.
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                        input int zs, input bit slt_ok);
        bit tmo;
        logic z;
        logic [W-1:0] mv;
        wait_phase(mk(3'd0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'd0),
                   mk(3'd0, 2'b00, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 2'b00, 3'd0), fw, tmo);
        if (tmo) begin need_reset = 1'b1; return; end
        if (op == J) begin
            push(mk(3'd1, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 3'd0), rbit(), rbit());
            return;
        end
        push(mk(3'd1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'd0), rbit(), rbit());
        if (!op_legal(op, fn, slt_ok)) begin
            push_halt(2'b01);
            need_reset = 1'b1;
            return;
        end
        z = (zs < 0) ? rbit() : zs[0];
        push(exec_v(op, fn, z), rbit(), z);
        if (op == BEQ || op == BNE) return;
        if (op == LW || op == SW) begin
            mv = mk(3'd3, 2'b00, 1, (op == SW), 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'd0);
            wait_phase(mv, mv, mw, tmo);
            if (tmo) begin need_reset = 1'b1; return; end
            if (op == SW) return;
        end
        push(mk(3'd4, 2'b00, 0, 0, 0, 0, 0, 2'b00, (op == R), 1, (op == LW), 0, 2'b00, 3'd0), rbit(), rbit());
    endtask

    // ---------------- driver tasks ----------------
    // Starts and ends on a falling edge; outputs are compared 1 ns after inputs change.
    task automatic run(input string tag, input bit use_b, input int max_n);
        int n = 0;
        logic [W-1:0] e;
        while (exp_q.size() > 0 && (max_n < 0 || n < max_n)) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            zero = z_q.pop_front();
            #1;
            check($sformatf("%s_c%0d", tag, n), use_b ? obs_b : obs_a, e);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = rbit();
        #1;
        check("rst_a", obs_a, '0);
        check("rst_b", obs_b, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_a", obs_a, '0);
        @(negedge clk);
        need_reset = 1'b0;
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input int fw, input int mw, input int zs, input bit use_b);
        OpCode = op;
        funct = fn;
        plan(op, fn, fw, mw, zs, !use_b);
        run(tag, use_b, -1);
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] ops[9] = '{R, J, BEQ, BNE, SLTI, ORI, LUI, LW, SW};
    logic [5:0] fns[3] = '{ADDU, SUBU, SLT};

    initial begin
        logic [5:0] op, fn;
        int fw, mw;
        do_reset();

        // Directed cases
        do_instr("lw", LW, 6'd0, 0, 0, -1, 1'b0);
        do_instr("beq_t", BEQ, 6'd0, 0, 0, 1, 1'b0);
        do_instr("beq_n", BEQ, 6'd0, 0, 0, 0, 1'b0);
        do_instr("bne_t", BNE, 6'd0, 1, 0, 0, 1'b0);
        do_instr("sw_w3", SW, 6'd0, 0, 3, -1, 1'b0);
        do_instr("j", J, 6'd0, 2, 0, -1, 1'b0);
        do_instr("r_slt", R, SLT, 0, 0, -1, 1'b0);
        do_instr("fetch_tmo", LW, 6'd0, TMO, 0, -1, 1'b0);
        do_reset();
        do_instr("mem_tmo", LW, 6'd0, 0, TMO, -1, 1'b0);
        do_reset();
        do_instr("ill", 6'b111111, 6'd0, 0, 0, -1, 1'b0);
        do_reset();
        do_instr("after_rst", ORI, 6'd0, 0, 0, -1, 1'b0);

        // Configuration without slt / slti
        do_reset();
        do_instr("noslt_r", R, SLT, 0, 0, -1, 1'b1);
        do_reset();
        do_instr("noslt_i", SLTI, 6'd0, 1, 0, -1, 1'b1);
        do_reset();
        do_instr("noslt_add", R, ADDU, 0, 0, -1, 1'b1);

        // Reset asserted in the middle of a lw MEM phase
        do_reset();
        OpCode = LW;
        funct = 6'd0;
        plan(LW, 6'd0, 0, 6, -1, 1'b1);
        run("lw_pre", 1'b0, 5);
        exp_q.delete();
        rdy_q.delete();
        z_q.delete();
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_mid_mem", obs_a, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("rst_hold%0d", i), obs_a, '0);
        end
        rst_n = 1'b1;
        #1;
        check("rst_mid_rel", obs_a, '0);
        @(negedge clk);
        do_instr("lw_again", LW, 6'd0, 0, 0, -1, 1'b0);

        // Randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            int pick = $urandom_range(0, 9);
            if (pick == 9) begin
                do op = 6'($urandom_range(0, 63)); while (op_legal(op, 6'd0, 1'b1) || op == R);
            end else begin
                op = ops[pick];
            end
            fn = (op == R) ? fns[$urandom_range(0, 2)] : 6'($urandom_range(0, 63));
            if ($urandom_range(0, 12) == 0) fn = 6'($urandom_range(0, 63));
            fw = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, 3);
            mw = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, 3);
            do_instr($sformatf("rnd%0d_op%02h", k, op), op, fn, fw, mw, -1, 1'b0);
            if (need_reset) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
